// File: rtl/nco_mod_cnt.sv
// ============================================================================
// nco_mod_cnt : tick-enable NCO divider driving an up/down modulo-MOD counter
// Optional macro CNT_BCD_EN adds a registered two-digit BCD copy of out.
// Revision: 1.0
// ============================================================================
`default_nettype none

module nco_mod_cnt #(
  parameter int DIV_W = 32,
  parameter int WIDTH = 6,
  parameter int MOD   = 60
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [DIV_W-1:0] num,
  input  logic             en,
  input  logic             up_dn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic             tick,
  output logic [WIDTH-1:0] out,
`ifdef CNT_BCD_EN
  output logic [7:0]       out_bcd,
`endif
  output logic             carry
);

  localparam logic [WIDTH-1:0] c_MAX_VAL = WIDTH'(MOD - 1);

  generate
    if (MOD < 2 || (64'd1 << WIDTH) < 64'(MOD)) begin : g_bad_mod
      $error("nco_mod_cnt: MOD must be >= 2 and fit in WIDTH bits");
    end
`ifdef CNT_BCD_EN
    if (MOD > 100) begin : g_bad_bcd
      $error("nco_mod_cnt: BCD output requires MOD <= 100");
    end
`endif
  endgenerate

  logic [DIV_W-1:0] r_div_cnt;
  logic             r_tick;
  logic [WIDTH-1:0] r_out;
  logic             r_carry;
  logic             w_div_last;
  logic [WIDTH-1:0] w_out_nxt;
  logic             w_carry_nxt;

  // >= rather than == so a num lowered mid-period cannot strand the counter
  assign w_div_last = (num <= DIV_W'(1)) || (r_div_cnt >= num - DIV_W'(1));

  always_comb begin
    w_out_nxt   = r_out;
    w_carry_nxt = 1'b0;
    if (load) begin
      w_out_nxt = (load_val > c_MAX_VAL) ? c_MAX_VAL : load_val;
    end else if (r_tick && en) begin
      if (up_dn) begin
        w_out_nxt   = (r_out >= c_MAX_VAL) ? '0 : r_out + WIDTH'(1);
        w_carry_nxt = (r_out == c_MAX_VAL);
      end else begin
        w_out_nxt   = (r_out == '0) ? c_MAX_VAL : r_out - WIDTH'(1);
        w_carry_nxt = (r_out == '0);
      end
    end
  end

`ifdef CNT_BCD_EN
  logic [7:0] r_out_bcd;
  logic [7:0] w_bin;
  logic [7:0] w_bcd_nxt;

  assign w_bin     = 8'(w_out_nxt);
  assign w_bcd_nxt = {4'(w_bin / 8'd10), 4'(w_bin % 8'd10)};

  always_ff @(posedge clk) begin
    if (rst) r_out_bcd <= 8'h00;
    else     r_out_bcd <= w_bcd_nxt;
  end

  assign out_bcd = r_out_bcd;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_div_cnt <= '0;
      r_tick    <= 1'b0;
      r_out     <= '0;
      r_carry   <= 1'b0;
    end else begin
      if (en) begin
        r_tick    <= w_div_last;
        r_div_cnt <= w_div_last ? '0 : r_div_cnt + DIV_W'(1);
      end else begin
        r_tick    <= 1'b0;
      end
      r_out   <= w_out_nxt;
      r_carry <= w_carry_nxt;
    end
  end

  assign tick  = r_tick;
  assign out   = r_out;
  assign carry = r_carry;

endmodule

`default_nettype wire

// File: tb/tb_nco_mod_cnt.sv
// ============================================================================
// tb_nco_mod_cnt : directed vector table plus multi-cycle sequences
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_nco_mod_cnt;

  typedef struct {
    logic        rst;
    logic        en;
    logic        up;
    logic        ld;
    logic [31:0] num;
    logic [5:0]  lv;
    logic        t;
    logic [5:0]  o;
    logic        c;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] num;
  logic        en;
  logic        up_dn;
  logic        load;
  logic [5:0]  load_val;
  logic        tick;
  logic [5:0]  out;
  logic        carry;
`ifdef CNT_BCD_EN
  logic [7:0]  out_bcd;
`endif

  int n_pass = 0;
  int n_tot  = 0;
  vec_t tbl[$];

  nco_mod_cnt #(.DIV_W(32), .WIDTH(6), .MOD(60)) dut (
    .clk      (clk),
    .rst      (rst),
    .num      (num),
    .en       (en),
    .up_dn    (up_dn),
    .load     (load),
    .load_val (load_val),
    .tick     (tick),
    .out      (out),
`ifdef CNT_BCD_EN
    .out_bcd  (out_bcd),
`endif
    .carry    (carry)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act !== exp) $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    else n_pass++;
  endtask

  function automatic logic [7:0] bcd(input logic [5:0] v);
    return {4'(v / 6'd10), 4'(v % 6'd10)};
  endfunction

  task automatic chk_all(input string nm, input logic t, input logic [5:0] o, input logic c);
    chk({nm, " tick"}, 32'(tick), 32'(t));
    chk({nm, " out"}, 32'(out), 32'(o));
    chk({nm, " carry"}, 32'(carry), 32'(c));
`ifdef CNT_BCD_EN
    chk({nm, " bcd"}, 32'(out_bcd), 32'(bcd(o)));
`endif
  endtask

  task automatic add(input logic r, input logic e, input logic u, input logic l,
                     input logic [31:0] nm, input logic [5:0] lv,
                     input logic t, input logic [5:0] o, input logic c);
    vec_t v;
    v.rst = r; v.en = e; v.up = u; v.ld = l; v.num = nm; v.lv = lv;
    v.t = t; v.o = o; v.c = c;
    tbl.push_back(v);
  endtask

  initial begin
    // reset held with load and en active
    for (int i = 0; i < 3; i++) add(1, 1, 1, 1, 4, 6'd5, 0, 0, 0);
    // first tick a full 4 cycles after release, out lags tick by one cycle
    add(0, 1, 1, 0, 4, 0, 0, 0, 0);
    add(0, 1, 1, 0, 4, 0, 0, 0, 0);
    add(0, 1, 1, 0, 4, 0, 0, 0, 0);
    add(0, 1, 1, 0, 4, 0, 1, 0, 0);
    add(0, 1, 1, 0, 4, 0, 0, 1, 0);
    add(0, 1, 1, 0, 4, 0, 0, 1, 0);
    add(0, 1, 1, 0, 4, 0, 0, 1, 0);
    add(0, 1, 1, 0, 4, 0, 1, 1, 0);
    add(0, 1, 1, 0, 4, 0, 0, 2, 0);
    // up wrap 58 -> 59 -> 0
    add(0, 1, 1, 1, 4, 6'd58, 0, 58, 0);
    add(0, 1, 1, 0, 4, 0, 0, 58, 0);
    add(0, 1, 1, 0, 4, 0, 1, 58, 0);
    add(0, 1, 1, 0, 4, 0, 0, 59, 0);
    add(0, 1, 1, 0, 4, 0, 0, 59, 0);
    add(0, 1, 1, 0, 4, 0, 0, 59, 0);
    add(0, 1, 1, 0, 4, 0, 1, 59, 0);
    add(0, 1, 1, 0, 4, 0, 0, 0, 1);
    add(0, 1, 1, 0, 4, 0, 0, 0, 0);
    // down wrap 1 -> 0 -> 59
    add(0, 1, 0, 1, 4, 6'd1, 0, 1, 0);
    add(0, 1, 0, 0, 4, 0, 1, 1, 0);
    add(0, 1, 0, 0, 4, 0, 0, 0, 0);
    add(0, 1, 0, 0, 4, 0, 0, 0, 0);
    add(0, 1, 0, 0, 4, 0, 0, 0, 0);
    add(0, 1, 0, 0, 4, 0, 1, 0, 0);
    add(0, 1, 0, 0, 4, 0, 0, 59, 1);
    add(0, 1, 0, 0, 4, 0, 0, 59, 0);
    // clamp of out-of-range load value
    add(0, 1, 0, 1, 4, 6'd10, 0, 10, 0);
    add(0, 1, 0, 1, 4, 6'd63, 1, 59, 0);
    add(0, 1, 0, 0, 4, 0, 0, 58, 0);
    add(0, 1, 0, 0, 4, 0, 0, 58, 0);
    add(0, 1, 0, 0, 4, 0, 0, 58, 0);
    add(0, 1, 0, 0, 4, 0, 1, 58, 0);
    // load collides with tick: load wins, tick not replayed
    add(0, 1, 1, 1, 4, 6'd20, 0, 20, 0);
    add(0, 1, 1, 0, 4, 0, 0, 20, 0);
    add(0, 1, 1, 0, 4, 0, 0, 20, 0);
    // en low for 10 cycles with div_cnt at 3, then resume
    for (int i = 0; i < 10; i++) add(0, 0, 1, 0, 4, 0, 0, 20, 0);
    add(0, 1, 1, 0, 4, 0, 1, 20, 0);
    add(0, 1, 1, 0, 4, 0, 0, 21, 0);
    // num = 1 and num = 0 tick on every enabled cycle
    add(0, 1, 1, 0, 1, 0, 1, 21, 0);
    add(0, 1, 1, 0, 1, 0, 1, 22, 0);
    add(0, 1, 1, 0, 0, 0, 1, 23, 0);
    add(0, 1, 1, 0, 0, 0, 1, 24, 0);

    rst = 1'b1; en = 1'b1; up_dn = 1'b1; load = 1'b1; load_val = 6'd5; num = 32'd4;
    foreach (tbl[i]) begin
      rst = tbl[i].rst; en = tbl[i].en; up_dn = tbl[i].up; load = tbl[i].ld;
      num = tbl[i].num; load_val = tbl[i].lv;
      cyc();
      chk_all($sformatf("row%0d", i), tbl[i].t, tbl[i].o, tbl[i].c);
    end

    // num lowered from 1000 to 3 with div_cnt at 500
    begin
      int ticks;
      ticks = 0;
      num = 32'd1000;
      for (int i = 0; i < 500; i++) begin
        cyc();
        if (tick) ticks++;
      end
      chk("num1000 no tick", 32'(ticks), 32'd0);
      chk("num1000 out", 32'(out), 32'd25);
      num = 32'd3;
      cyc(); chk_all("num3 e1", 1, 25, 0);
      cyc(); chk_all("num3 e2", 0, 26, 0);
      cyc(); chk_all("num3 e3", 0, 26, 0);
      cyc(); chk_all("num3 e4", 1, 26, 0);
    end

    // full wrap from reset: out = (n-1)/4 mod 60, carry every 240 cycles
    rst = 1'b1; load = 1'b0; num = 32'd4; up_dn = 1'b1; en = 1'b1;
    cyc();
    chk_all("rst2", 0, 0, 0);
    rst = 1'b0;
    for (int n = 1; n <= 490; n++) begin
      logic [5:0] eo;
      cyc();
      eo = 6'(((n - 1) / 4) % 60);
      chk_all($sformatf("wrap n%0d", n), (n % 4) == 0, eo,
              (n > 1) && (((n - 1) % 240) == 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule

`default_nettype wire
